// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NRD combinational reads with write forwarding, two write ports, load-busy scoreboard.
// Reads have 0 latency; writes and scoreboard commit at the edge; there is no backpressure, and the hazard unit stalls issue using rd_busy.
module regfile_mp_sb #(
  parameter int               XLEN    = 32,
  parameter int               NREG    = 32,
  parameter int               NRD     = 2,
  parameter int               SP_IDX  = 2,
  parameter logic [XLEN-1:0]  SP_INIT = XLEN'(1024),
  localparam int              AW      = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wa_en,
  input  logic [AW-1:0]        wa_addr,
  input  logic [XLEN-1:0]      wa_data,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_rd,
  output logic [NREG-1:0]      busy_vec,
  output logic                 wr_conflict,
  output logic [AW:0]          busy_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_conflict;
  logic [AW:0]     r_cnt;

  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     w_cnt_nxt;
  logic            w_conflict_nxt;

  assign w_conflict_nxt = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != '0);

  // A new issue overrides a same-cycle load return: the new load is still outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en)
      w_busy_nxt[wb_addr] = 1'b0;
    if (iss_en && (iss_rd != '0))
      w_busy_nxt[iss_rd] = 1'b1;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 0; r < NREG; r++)
      w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[r]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        r_regs[r] <= (r == SP_IDX) ? SP_INIT : '0;
      r_busy     <= '0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (wa_en && (wa_addr != '0))
        r_regs[wa_addr] <= wa_data;
      // Port B is applied last so it wins on an address collision.
      if (wb_en && (wb_addr != '0))
        r_regs[wb_addr] <= wb_data;
      r_busy     <= w_busy_nxt;
      r_conflict <= w_conflict_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] == '0)
        rd_data[i*XLEN +: XLEN] = '0;
      else if (!rst && wb_en && (wb_addr == rd_addr[i*AW +: AW]))
        rd_data[i*XLEN +: XLEN] = wb_data;
      else if (!rst && wa_en && (wa_addr == rd_addr[i*AW +: AW]))
        rd_data[i*XLEN +: XLEN] = wa_data;
      else
        rd_data[i*XLEN +: XLEN] = r_regs[rd_addr[i*AW +: AW]];
      rd_busy[i] = r_busy[rd_addr[i*AW +: AW]] &&
                   !(wb_en && (wb_addr == rd_addr[i*AW +: AW]));
    end
  end

  assign busy_vec    = r_busy;
  assign wr_conflict = r_conflict;
  assign busy_cnt    = r_cnt;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus a randomized model run.
module tb_regfile_mp_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wa_en, wb_en, iss_en;
  logic [AW-1:0]       wa_addr, wb_addr, iss_rd;
  logic [XLEN-1:0]     wa_data, wb_data;
  logic [NREG-1:0]     busy_vec;
  logic                wr_conflict;
  logic [AW:0]         busy_cnt;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q [$];

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .SP_IDX(2), .SP_INIT(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wa_en = 0; wb_en = 0; iss_en = 0;
    wa_addr = '0; wb_addr = '0; iss_rd = '0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] e, got;
    idle();
    rst = 1; rd_addr = '0;
    tick();
    rst = 0;
    #1;
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec); end
    total++; if (busy_cnt !== '0) begin bad++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt); end
    total++; if (wr_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", wr_conflict); end
    for (int r = 0; r < NREG; r += 2) begin
      rd_addr = {AW'(r + 1), AW'(r)};
      exp_q.push_back((r == 2) ? 32'd1024 : 32'd0);
      exp_q.push_back(32'd0);
      #1;
      for (int p = 0; p < 2; p++) begin
        e = exp_q.pop_front();
        got = rd_data[p*XLEN +: XLEN];
        total++; if (got !== e) begin bad++; $display("FAIL reset_read x%0d got=%h exp=%h", r + p, got, e); end
      end
    end
  endtask

  task automatic test_fwd_a();
    logic [XLEN-1:0] e;
    @(negedge clk);
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rd_addr = {AW'(0), AW'(5)};
    exp_q.push_back(32'hDEADBEEF);
    #1; e = exp_q.pop_front();
    total++; if (rd_data[31:0] !== e) begin bad++; $display("FAIL fwd_a got=%h exp=%h", rd_data[31:0], e); end
    tick(); idle();
    exp_q.push_back(32'hDEADBEEF);
    #1; e = exp_q.pop_front();
    total++; if (rd_data[31:0] !== e) begin bad++; $display("FAIL stored_a got=%h exp=%h", rd_data[31:0], e); end
  endtask

  task automatic test_conflict();
    logic [XLEN-1:0] e;
    @(negedge clk);
    wa_en = 1; wa_addr = 7; wa_data = 32'h11;
    wb_en = 1; wb_addr = 7; wb_data = 32'h22;
    rd_addr = {AW'(7), AW'(7)};
    exp_q.push_back(32'h22);
    #1; e = exp_q.pop_front();
    total++; if (rd_data[63:32] !== e) begin bad++; $display("FAIL conflict_fwd got=%h exp=%h", rd_data[63:32], e); end
    tick(); idle();
    exp_q.push_back(32'h22);
    #1; e = exp_q.pop_front();
    total++; if (rd_data[31:0] !== e) begin bad++; $display("FAIL conflict_store got=%h exp=%h", rd_data[31:0], e); end
    total++; if (wr_conflict !== 1'b1) begin bad++; $display("FAIL conflict_flag got=%b exp=1", wr_conflict); end
    tick(); #1;
    total++; if (wr_conflict !== 1'b0) begin bad++; $display("FAIL conflict_clear got=%b exp=0", wr_conflict); end
  endtask

  task automatic test_busy();
    logic [XLEN-1:0] e;
    @(negedge clk);
    iss_en = 1; iss_rd = 9;
    tick(); idle();
    rd_addr = {AW'(0), AW'(9)};
    #1;
    total++; if (busy_vec[9] !== 1'b1) begin bad++; $display("FAIL busy_set got=%b exp=1", busy_vec[9]); end
    total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL busy_cnt1 got=%0d exp=1", busy_cnt); end
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL rd_busy_set got=%b exp=1", rd_busy[0]); end
    wb_en = 1; wb_addr = 9; wb_data = 32'h55;
    exp_q.push_back(32'h55);
    #1; e = exp_q.pop_front();
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL rd_busy_unblock got=%b exp=0", rd_busy[0]); end
    total++; if (rd_data[31:0] !== e) begin bad++; $display("FAIL load_fwd got=%h exp=%h", rd_data[31:0], e); end
    tick(); idle(); #1;
    total++; if (busy_vec[9] !== 1'b0) begin bad++; $display("FAIL busy_clear got=%b exp=0", busy_vec[9]); end
    total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL busy_cnt0 got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    iss_en = 1; iss_rd = 4;
    tick(); idle();
    iss_en = 1; iss_rd = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h77;
    tick(); idle();
    rd_addr = {AW'(4), AW'(0)};
    #1;
    total++; if (busy_vec[4] !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", busy_vec[4]); end
    total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL set_wins_cnt got=%0d exp=1", busy_cnt); end
    total++; if (rd_busy[1] !== 1'b1) begin bad++; $display("FAIL set_wins_rd got=%b exp=1", rd_busy[1]); end
    wa_en = 1; wa_addr = 4; wa_data = 32'h99;
    tick(); idle(); #1;
    total++; if (busy_vec[4] !== 1'b1) begin bad++; $display("FAIL wa_no_clear got=%b exp=1", busy_vec[4]); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
    iss_en = 1; iss_rd = 0;
    rd_addr = '0;
    #1;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL x0_fwd got=%h exp=0", rd_data); end
    tick(); idle(); #1;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL x0_store got=%h exp=0", rd_data); end
    total++; if (busy_vec[0] !== 1'b0) begin bad++; $display("FAIL x0_busy got=%b exp=0", busy_vec[0]); end
    total++; if (rd_busy !== '0) begin bad++; $display("FAIL x0_rd_busy got=%b exp=0", rd_busy); end
    total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL x0_cnt got=%0d exp=1", busy_cnt); end
    total++; if (wr_conflict !== 1'b0) begin bad++; $display("FAIL x0_conflict got=%b exp=0", wr_conflict); end
  endtask

  task automatic test_reset_mid();
    logic [NREG-1:0] eb;
    @(negedge clk);
    iss_en = 1; iss_rd = 3;
    tick(); idle();
    iss_en = 1; iss_rd = 6; wa_en = 1; wa_addr = 10; wa_data = 32'h1234;
    tick(); idle();
    eb = '0; eb[3] = 1; eb[4] = 1; eb[6] = 1;
    #1;
    total++; if (busy_vec !== eb) begin bad++; $display("FAIL pre_rst_busy got=%h exp=%h", busy_vec, eb); end
    total++; if (busy_cnt !== 6'd3) begin bad++; $display("FAIL pre_rst_cnt got=%0d exp=3", busy_cnt); end
    rst = 1; iss_en = 1; iss_rd = 12; wa_en = 1; wa_addr = 11; wa_data = 32'hABCD;
    rd_addr = {AW'(10), AW'(11)};
    #1;
    total++; if (rd_data[31:0] !== 32'd0) begin bad++; $display("FAIL rst_no_fwd got=%h exp=0", rd_data[31:0]); end
    total++; if (rd_data[63:32] !== 32'h1234) begin bad++; $display("FAIL rst_show_state got=%h exp=1234", rd_data[63:32]); end
    tick(); rst = 0; idle();
    rd_addr = {AW'(2), AW'(10)};
    #1;
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL mid_rst_busy got=%h exp=0", busy_vec); end
    total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", busy_cnt); end
    total++; if (rd_data[31:0] !== 32'd0) begin bad++; $display("FAIL mid_rst_x10 got=%h exp=0", rd_data[31:0]); end
    total++; if (rd_data[63:32] !== 32'd1024) begin bad++; $display("FAIL mid_rst_sp got=%h exp=400", rd_data[63:32]); end
    rd_addr = {AW'(0), AW'(11)};
    #1;
    total++; if (rd_data[31:0] !== 32'd0) begin bad++; $display("FAIL mid_rst_x11 got=%h exp=0", rd_data[31:0]); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] m [NREG];
    logic [NREG-1:0] mb;
    logic            mc;
    logic [AW-1:0]   a;
    logic [XLEN-1:0] e;
    logic [NRD-1:0]  eb;
    @(negedge clk);
    idle(); rst = 1;
    tick(); rst = 0;
    for (int r = 0; r < NREG; r++) m[r] = (r == 2) ? 32'd1024 : 32'd0;
    mb = '0; mc = 0;
    for (int n = 0; n < 300; n++) begin
      wa_en = 1'($urandom_range(0, 1)); wa_addr = AW'($urandom_range(0, 7)); wa_data = $urandom;
      wb_en = 1'($urandom_range(0, 1)); wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
      iss_en = 1'($urandom_range(0, 1)); iss_rd = AW'($urandom_range(0, 7));
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      eb = '0;
      for (int p = 0; p < NRD; p++) begin
        a = rd_addr[p*AW +: AW];
        if (a == 0) e = '0;
        else if (wb_en && wb_addr == a) e = wb_data;
        else if (wa_en && wa_addr == a) e = wa_data;
        else e = m[a];
        exp_q.push_back(e);
        eb[p] = mb[a] && !(wb_en && wb_addr == a);
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
        e = exp_q.pop_front();
        total++; if (rd_data[p*XLEN +: XLEN] !== e) begin bad++; $display("FAIL rand_rd%0d n=%0d got=%h exp=%h", p, n, rd_data[p*XLEN +: XLEN], e); end
      end
      total++; if (rd_busy !== eb) begin bad++; $display("FAIL rand_rd_busy n=%0d got=%b exp=%b", n, rd_busy, eb); end
      total++; if (busy_vec !== mb) begin bad++; $display("FAIL rand_busy_vec n=%0d got=%h exp=%h", n, busy_vec, mb); end
      total++; if (busy_cnt !== 6'($countones(mb))) begin bad++; $display("FAIL rand_busy_cnt n=%0d got=%0d exp=%0d", n, busy_cnt, $countones(mb)); end
      total++; if (wr_conflict !== mc) begin bad++; $display("FAIL rand_conflict n=%0d got=%b exp=%b", n, wr_conflict, mc); end
      mc = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 0);
      if (wa_en && wa_addr != 0) m[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m[wb_addr] = wb_data;
      if (wb_en) mb[wb_addr] = 1'b0;
      if (iss_en && iss_rd != 0) mb[iss_rd] = 1'b1;
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1; rd_addr = '0;
    idle();
    test_reset();
    test_fwd_a();
    test_conflict();
    test_busy();
    test_set_wins();
    test_x0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
